// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Contents: FSM state enum, default operand width, and the special-case
// result constants (all-ones quotient, minimum signed value).
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] QUO_ALL_ONES = {DIV_WIDTH{1'b1}};
  localparam logic [DIV_WIDTH-1:0] SIGNED_MIN   = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_addsub.sv
// W-bit adder/subtractor used by the divider iteration and remainder fix.
// Ports:
//   a, b : operands
//   sub  : 1 -> sum = a - b, 0 -> sum = a + b (modulo 2^W)
//   sum  : result
// Carries are looked ahead within 4-bit groups; group carries chain.
module div_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  localparam int unsigned GRP = 4;

  logic [W-1:0] bx;
  logic [W-1:0] prop;
  logic [W-1:0] carry;
  logic         acc;

  // Subtraction is a + ~b + 1; the +1 enters as the carry into bit 0.
  always_comb begin
    bx       = b ^ {W{sub}};
    prop     = a ^ bx;
    carry    = '0;
    acc      = 1'b0;
    carry[0] = sub;
    for (int unsigned i = 1; i < W; i++) begin
      // Expand the carry into bit i from its group's incoming carry.
      acc = carry[((i - 1) / GRP) * GRP];
      for (int unsigned j = ((i - 1) / GRP) * GRP; j < i; j++) begin
        acc = (a[j] & bx[j]) | (prop[j] & acc);
      end
      carry[i] = acc;
    end
    sum = prop ^ carry;
  end

endmodule

// File: rtl/seq_divider_32.sv
// Sequential signed/unsigned integer divider, one quotient bit per cycle
// (non-restoring, WIDTH+1-bit partial remainder).
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   dividend, divisor    : operands
//   signed_op            : 1 = two's-complement, 0 = unsigned
//   out_valid / out_ready: result handshake (out_valid only in DONE)
//   quotient, remainder  : results (truncating division)
//   div_by_zero          : divisor was zero
// Build option: define SEQ_DIVIDER_EARLY_OUT_EN to finish in one cycle when
// the divisor magnitude exceeds the dividend magnitude.
module seq_divider_32
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned    CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  // Width-generic forms of the package special-case constants.
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{QUO_ALL_ONES[0]}};
  localparam logic [WIDTH-1:0] MIN_VAL = {SIGNED_MIN[DIV_WIDTH-1], {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] qacc_q, qacc_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             in_ready_d, out_valid_d, dbz_d;
  logic [WIDTH-1:0] quo_d, rem_d;

  logic             dvd_neg, dvs_neg, accept, is_zero, is_ovf;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, step;
  logic [WIDTH-1:0] corr, rem_fix, q_next;

  // Operand decode: magnitudes and special cases.
  always_comb begin
    dvd_neg = signed_op & dividend[WIDTH-1];
    dvs_neg = signed_op & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    dvs_mag = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
    accept  = in_valid & in_ready;
    is_zero = (divisor == '0);
    is_ovf  = signed_op & (dividend == MIN_VAL) & (divisor == ONES);
  end

  // One non-restoring step: subtract when the remainder is non-negative,
  // add back otherwise; the new quotient bit is the inverted result sign.
  assign shifted = {prem_q[WIDTH-1:0], qacc_q[WIDTH-1]};

  div_addsub #(.W(WIDTH + 1)) u_step (
    .a   (shifted),
    .b   ({1'b0, dmag_q}),
    .sub (~prem_q[WIDTH]),
    .sum (step)
  );

  // Final correction: a negative last remainder gets the divisor added back.
  div_addsub #(.W(WIDTH)) u_corr (
    .a   (step[WIDTH-1:0]),
    .b   (dmag_q),
    .sub (1'b0),
    .sum (corr)
  );

  assign q_next  = {qacc_q[WIDTH-2:0], ~step[WIDTH]};
  assign rem_fix = step[WIDTH] ? corr : step[WIDTH-1:0];

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    prem_d  = prem_q;
    qacc_d  = qacc_q;
    dmag_d  = dmag_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quotient;
    rem_d   = remainder;
    dbz_d   = div_by_zero;

    case (state_q)
      IDLE: begin
        if (accept) begin
          dbz_d = 1'b0;
          if (is_zero) begin
            state_d = DONE;
            quo_d   = ONES;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else if (is_ovf) begin
            state_d = DONE;
            quo_d   = MIN_VAL;
            rem_d   = '0;
          end
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
          else if (dvs_mag > dvd_mag) begin
            state_d = DONE;
            quo_d   = '0;
            rem_d   = dividend;
          end
`endif
          else begin
            state_d = BUSY;
            prem_d  = '0;
            qacc_d  = dvd_mag;
            dmag_d  = dvs_mag;
            cnt_d   = '0;
            qneg_d  = dvd_neg ^ dvs_neg;
            rneg_d  = dvd_neg;
          end
        end
      end
      BUSY: begin
        prem_d = step;
        qacc_d = q_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quo_d   = qneg_q ? (~q_next + WIDTH'(1)) : q_next;
          rem_d   = rneg_q ? (~rem_fix + WIDTH'(1)) : rem_fix;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      prem_q      <= '0;
      qacc_q      <= '0;
      dmag_q      <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      prem_q      <= prem_d;
      qacc_q      <= qacc_d;
      dmag_q      <= dmag_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      quotient    <= quo_d;
      remainder   <= rem_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule

// File: doc/seq_divider_32.md
SEQ_DIVIDER_32 -- requirements
Module: seq_divider_32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, operands present.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 The block SHALL have ports dividend and divisor, input, WIDTH each, the operands.
REQ-007 The block SHALL have port signed_op, input, 1, which selects two's-complement operation when high and unsigned when low.
REQ-008 The block SHALL have port out_valid, output, 1, result present.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 The block SHALL have ports quotient and remainder, output, WIDTH each, the results.
REQ-011 The block SHALL have port div_by_zero, output, 1, flag set when the divisor was zero.

Function
REQ-012 The block SHALL use an FSM with states IDLE, BUSY and DONE; in_ready SHALL be high only in IDLE, and out_valid SHALL be high only in DONE.
REQ-013 The block SHALL take the IDLE->BUSY transition on in_valid&&in_ready, registering operand magnitudes, signed_op, quotient sign (operand signs differ) and remainder sign (dividend sign).
REQ-014 In BUSY the block SHALL resolve one quotient bit per cycle by non-restoring division on a WIDTH+1-bit partial remainder, with a final remainder correction in the last iteration.
REQ-015 After WIDTH iterations the block SHALL go BUSY->DONE; out_valid SHALL assert exactly WIDTH+1 cycles after the accept edge.
REQ-016 On entering DONE the block SHALL apply the registered sign fix-up to quotient and remainder.
REQ-017 The block SHALL hold quotient, remainder, div_by_zero and out_valid stable in DONE until out_valid&&out_ready, then go DONE->IDLE.
REQ-018 The block SHALL allow in_ready to rise the cycle after the result handshake; it SHALL NOT accept a new operation in the same cycle as that handshake.
REQ-019 For a zero divisor the block SHALL skip BUSY and go straight to DONE with quotient all ones, remainder equal to the dividend and div_by_zero set, so out_valid asserts 1 cycle after accept.
REQ-020 For a signed overflow (dividend=-2^(WIDTH-1), divisor=-1) the block SHALL go straight to DONE with quotient=-2^(WIDTH-1), remainder=0 and div_by_zero clear.
REQ-021 The block SHALL clear div_by_zero for every operation other than a zero divisor.
REQ-022 The block SHALL ignore in_valid outside IDLE, and SHALL ignore out_ready outside DONE.

Reset
REQ-023 Asserting rstn low SHALL put the FSM in IDLE and clear out_valid, quotient, remainder and div_by_zero to 0 without waiting for a clock edge.
REQ-024 While rstn is low, in_ready SHALL read 0.
REQ-025 in_ready SHALL rise 1 cycle after rstn is deasserted.
REQ-026 A reset arriving during BUSY or DONE SHALL abort the operation with no result produced.

Configuration
REQ-027 When the macro SEQ_DIVIDER_EARLY_OUT_EN is defined, an operation with divisor magnitude greater than dividend magnitude SHALL go straight to DONE (out_valid 1 cycle after accept) with quotient=0 and remainder=the original dividend.
REQ-028 When SEQ_DIVIDER_EARLY_OUT_EN is undefined, such an operation SHALL take the full WIDTH+1 latency and give identical results.

Structure
REQ-029 The package div_pkg SHALL hold the FSM state enum typedef, the default width constant and the special-case result constants (all-ones quotient, minimum signed value).
REQ-030 The WIDTH+1-bit add/subtract step SHALL be a separate sub-module div_addsub (inputs a, b, sub; output sum), with carry-lookahead structure matching the team's adder style.

Verification
REQ-031 The bench SHALL cover: unsigned 100/7 -> quotient=14, remainder=2, out_valid on cycle 33 after accept.
REQ-032 The bench SHALL cover: signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-033 The bench SHALL cover: 0x12345678/0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, out_valid 1 cycle after accept.
REQ-034 The bench SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-035 The bench SHALL cover: out_ready held low 10 cycles in DONE -> outputs stable and in_ready low throughout; in_ready rises the cycle after the handshake.
REQ-036 The bench SHALL cover: rstn pulsed low at BUSY cycle 5 -> immediate IDLE with outputs 0; a following 9/3 gives quotient=3, remainder=0; a random self-checking run of 65535 operations against a behavioural /,% model gives zero mismatches.
